ofm_deskew_16: RTL and testbench

//   Output collector directly downstream of the 16x16 uGEMM-rate systolic array.
//   The array drains column w's ofm word w cycles after column 0, so each result row leaves it skewed.

---
 rtl/ofm_deskew_16_if.sv | 26 ++
 rtl/ofm_deskew_16.sv | 121 ++++++++++++
 tb/tb_ofm_deskew_16.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ofm_deskew_16_if.sv
// Bundle between the systolic array drain, the deskew collector and the writeback stage.
// The array-side signals (ofm_vld/ofm) and the writeback-side handshake (out_*) share one bundle.
// The collector uses the slave modport and the environment uses the master modport.
interface ofm_deskew_16_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned OWIDTH = 16,
    parameter int unsigned DEPTH  = 4
);
    logic                      ofm_vld;
    logic [OWIDTH-1:0]         ofm [WIDTH-1:0];
    logic                      out_vld;
    logic                      out_rdy;
    logic [OWIDTH-1:0]         out_ofm [WIDTH-1:0];
    logic [$clog2(DEPTH):0]    fifo_cnt;
    logic                      ovf;

    modport slave (
        input  ofm_vld, ofm, out_rdy,
        output out_vld, out_ofm, fifo_cnt, ovf
    );

    modport master (
        output ofm_vld, ofm, out_rdy,
        input  out_vld, out_ofm, fifo_cnt, ovf
    );
endinterface

// File: rtl/ofm_deskew_16.sv
// ofm_deskew_16: realigns the column-skewed result rows of the systolic array into whole rows.
// Aligned rows are buffered in a small first-word fall-through FIFO for the writeback stage.
// The array cannot be stalled, so a row arriving while the FIFO is full is dropped.
// A dropped row sets the sticky ovf flag.
// Optional build macro OFM_RELU_EN applies ReLU to every aligned word before the FIFO write.
module ofm_deskew_16 #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned OWIDTH = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    ofm_deskew_16_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-2:0]  r_vld_pipe;
    logic              w_wr_vld;
    logic [OWIDTH-1:0] w_row [WIDTH-1:0];
    logic [OWIDTH-1:0] r_mem [DEPTH-1:0][WIDTH-1:0];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW-1:0]     w_head_ptr;
    logic [CW-1:0]     r_cnt;
    logic              r_ovf;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    // Row-valid delay line; clr also kills the ofm_vld sampled in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
        end else if (clr) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[WIDTH-3:0], bus.ofm_vld};
        end
    end

    assign w_wr_vld = r_vld_pipe[WIDTH-2];

    for (genvar c = 0; c < WIDTH; c++) begin : g_col
        logic [OWIDTH-1:0] w_aligned;

        if (c == WIDTH - 1) begin : g_direct
            // Last column drains last, so it is already aligned.
            assign w_aligned = bus.ofm[c];
        end else begin : g_chain
            localparam int unsigned D = WIDTH - 1 - c;
            logic [OWIDTH-1:0] r_chain [D];

            // Column c is delayed WIDTH-1-c cycles to line up with the last column.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) r_chain[k] <= '0;
                end else begin
                    r_chain[0] <= bus.ofm[c];
                    for (int k = 1; k < D; k++) r_chain[k] <= r_chain[k-1];
                end
            end

            assign w_aligned = r_chain[D-1];
        end

`ifdef OFM_RELU_EN
        assign w_row[c] = w_aligned[OWIDTH-1] ? '0 : w_aligned;
`else
        assign w_row[c] = w_aligned;
`endif

        assign bus.out_ofm[c] = r_mem[w_head_ptr][c];
    end

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_pop   = ~w_empty & bus.out_rdy;
    assign w_push  = w_wr_vld & (~w_full | w_pop);
    // When empty, point at the slot popped last so out_ofm keeps showing the last row.
    assign w_head_ptr = w_empty ? (r_rptr - PW'(1)) : r_rptr;

    // FIFO storage, pointers, occupancy and sticky overflow; clr beats push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < DEPTH; d++) begin
                for (int k = 0; k < WIDTH; k++) r_mem[d][k] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else if (clr) begin
            r_wptr <= r_rptr;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_push) begin
                for (int k = 0; k < WIDTH; k++) r_mem[r_wptr][k] <= w_row[k];
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_wr_vld && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.out_vld  = ~w_empty;
    assign bus.fifo_cnt = r_cnt;
    assign bus.ovf      = r_ovf;
endmodule

// File: tb/tb_ofm_deskew_16.sv
// Directed bench for ofm_deskew_16: rows are injected with the array's column skew.
// Per-cycle expectations come from hand-written vector tables and a few explicit sequences.
module tb_ofm_deskew_16;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned OWIDTH = 16;
    localparam int unsigned DEPTH  = 4;

    logic clk;
    logic rst_n;
    logic clr;

    ofm_deskew_16_if #(.WIDTH(WIDTH), .OWIDTH(OWIDTH), .DEPTH(DEPTH)) bus ();

    ofm_deskew_16 #(.WIDTH(WIDTH), .OWIDTH(OWIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int scen;
        bit rdy;
        bit ev;
        int ecnt;
        bit eovf;
        int ehead;
    } vec_t;

    vec_t vecs[$];
    int   sch_start[$];
    int   sch_id[$];
    int   cyc;
    int   n_chk;
    int   n_fail;

    function automatic void add(int scen, bit rdy, bit ev, int ecnt, bit eovf, int ehead);
        vec_t v;
        v.scen = scen; v.rdy = rdy; v.ev = ev; v.ecnt = ecnt; v.eovf = eovf; v.ehead = ehead;
        vecs.push_back(v);
    endfunction

    // Word w of row id; row 31 carries a negative word for the ReLU check.
    function automatic logic [15:0] rowval(int id, int w);
        if (id == 31 && w == 3) return 16'hFF00;
        if (id == 31 && w == 4) return 16'h0100;
        return 16'((id << 8) | (w + 1));
    endfunction

    function automatic logic [15:0] expval(int id, int w);
        logic [15:0] v;
        v = rowval(id, w);
`ifdef OFM_RELU_EN
        if (v[15]) v = '0;
`endif
        return v;
    endfunction

    task automatic sched(int id, int start);
        sch_start.push_back(start);
        sch_id.push_back(id);
    endtask

    // Drive one cycle of skewed array output, then advance past the next rising edge.
    task automatic step();
        bus.ofm_vld = 1'b0;
        for (int w = 0; w < WIDTH; w++) bus.ofm[w] = 16'hDEA0 | 16'(w);
        foreach (sch_start[i]) begin
            if (sch_start[i] == cyc) bus.ofm_vld = 1'b1;
            for (int w = 0; w < WIDTH; w++) begin
                if (sch_start[i] + w == cyc) bus.ofm[w] = rowval(sch_id[i], w);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check(string name, bit ev, int ecnt, bit eovf, int ehead);
        int bad;
        n_chk++;
        if (bus.out_vld !== ev) begin
            n_fail++;
            $display("FAIL %s out_vld: got %0b want %0b", name, bus.out_vld, ev);
        end
        n_chk++;
        if (bus.fifo_cnt !== 3'(ecnt)) begin
            n_fail++;
            $display("FAIL %s fifo_cnt: got %0d want %0d", name, bus.fifo_cnt, ecnt);
        end
        n_chk++;
        if (bus.ovf !== eovf) begin
            n_fail++;
            $display("FAIL %s ovf: got %0b want %0b", name, bus.ovf, eovf);
        end
        if (ev) begin
            n_chk++;
            bad = -1;
            for (int w = WIDTH - 1; w >= 0; w--) begin
                if (bus.out_ofm[w] !== expval(ehead, w)) bad = w;
            end
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL %s out_ofm[%0d]: got %h want %h (row %0d)", name, bad,
                         bus.out_ofm[bad], expval(ehead, bad), ehead);
            end
        end
    endtask

    task automatic run_table(int scen, int skip);
        int k;
        bus.out_rdy = 1'b0;
        repeat (skip) step();
        k = skip;
        foreach (vecs[i]) begin
            if (vecs[i].scen == scen) begin
                bus.out_rdy = vecs[i].rdy;
                step();
                check($sformatf("s%0d_k%0d", scen, k), vecs[i].ev, vecs[i].ecnt, vecs[i].eovf,
                      vecs[i].ehead);
                k++;
            end
        end
        bus.out_rdy = 1'b0;
    endtask

    initial begin
        int base;
        int bad;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;

        // Scenario 1 / 4 / 5: single row, out_rdy=1; entry k is the state after step k.
        add(1, 1, 0, 0, 0, 0);  add(1, 1, 1, 1, 0, 0);  add(1, 1, 0, 0, 0, 0);
        add(4, 1, 0, 0, 0, 0);  add(4, 1, 1, 1, 0, 31); add(4, 1, 0, 0, 0, 0);
        add(5, 1, 0, 0, 0, 0);  add(5, 1, 1, 1, 0, 22); add(5, 1, 0, 0, 0, 0);
        // Scenario 2: rows 1..5 back to back, stalled; row 5 dropped; then drained.
        add(2, 0, 0, 0, 0, 0);  add(2, 0, 1, 1, 0, 1);  add(2, 0, 1, 2, 0, 1);
        add(2, 0, 1, 3, 0, 1);  add(2, 0, 1, 4, 0, 1);  add(2, 0, 1, 4, 1, 1);
        add(2, 1, 1, 3, 1, 2);  add(2, 1, 1, 2, 1, 3);  add(2, 1, 1, 1, 1, 4);
        add(2, 1, 0, 0, 1, 0);  add(2, 1, 0, 0, 1, 0);
        // Scenario 3: rows 10..14, full FIFO popped on the cycle row 14 aligns.
        add(3, 0, 1, 4, 0, 10); add(3, 1, 1, 4, 0, 11); add(3, 1, 1, 3, 0, 12);
        add(3, 1, 1, 2, 0, 13); add(3, 1, 1, 1, 0, 14); add(3, 1, 0, 0, 0, 0);

        rst_n       = 1'b0;
        clr         = 1'b0;
        bus.ofm_vld = 1'b0;
        bus.out_rdy = 1'b0;
        for (int w = 0; w < WIDTH; w++) bus.ofm[w] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, 0, 0, 0);
        n_chk++;
        bad = -1;
        for (int w = 0; w < WIDTH; w++) if (bus.out_ofm[w] !== 16'h0) bad = w;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL reset out_ofm[%0d]: got %h want 0000", bad, bus.out_ofm[bad]);
        end
        rst_n = 1'b1;
        step();

        sched(0, cyc);
        run_table(1, 14);

        base = cyc;
        for (int r = 1; r <= 5; r++) sched(r, base + r - 1);
        run_table(2, 14);

        // clr with one row stored, one mid-skew and one starting in the clr cycle.
        base = cyc;
        sched(6, base);
        sched(7, base + 10);
        sched(8, base + 16);
        repeat (16) step();
        check("clr_pre", 1, 1, 1, 6);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr", 0, 0, 0, 0);
        repeat (20) step();
        check("clr_flush", 0, 0, 0, 0);

        base = cyc;
        for (int r = 0; r < 5; r++) sched(10 + r, base + r);
        run_table(3, 18);

        // Async reset while row 21 is in the skew pipe and row 20 is stored.
        base = cyc;
        sched(20, base);
        sched(21, base + 16);
        repeat (16) step();
        check("rst_pre", 1, 1, 0, 20);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("rst_async", 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b1;
        sched(22, cyc);
        run_table(5, 14);

        sched(31, cyc);
        run_table(4, 14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
